// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction-fetch unit with a prefetch queue. Issues word fetches
//             over a valid/ready request / valid response memory interface,
//             buffers up to DEPTH instructions tagged with their PC and hands
//             them to decode over a valid/ready handshake. Redirects flush the
//             queue; bus errors and misaligned targets become fault entries.
//  Ports    : clk, reset_n (async, active-low)
//             imem_req_valid/ready/addr      fetch request channel
//             imem_rsp_valid/data/err        in-order response, 1-cycle pulse
//             redirect_valid/pc              pipeline redirect
//             instr_valid/ready/data/pc/fault queue head towards decode
//             count                          valid entries in queue
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       XLEN     = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   output logic                         imem_req_valid,
   input  logic                         imem_req_ready,
   output logic [ADDR_W-1:0]            imem_req_addr,
   input  logic                         imem_rsp_valid,
   input  logic [XLEN-1:0]              imem_rsp_data,
   input  logic                         imem_rsp_err,
   input  logic                         redirect_valid,
   input  logic [ADDR_W-1:0]            redirect_pc,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic [XLEN-1:0]              instr_data,
   output logic [ADDR_W-1:0]            instr_pc,
   output logic                         instr_fault,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]   req_pc_q, req_pc_d;     // PC of the outstanding request
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                run_ok_q, run_ok_d;     // keeps the request low for the first cycle after reset

   logic [XLEN-1:0]     data_q  [DEPTH];
   logic [XLEN-1:0]     data_d  [DEPTH];
   logic [ADDR_W-1:0]   pc_q    [DEPTH];
   logic [ADDR_W-1:0]   pc_d    [DEPTH];
   logic                fault_q [DEPTH];
   logic                fault_d [DEPTH];

   logic                req_fire;
   logic                pop;
   logic                push;
   logic [XLEN-1:0]     push_data;
   logic                push_fault;
   logic                owed;
   logic                misaligned;

   // A request can only be raised in RUN, where nothing is outstanding, so a
   // free queue slot is guaranteed for its response.
   assign imem_req_valid = run_ok_q && (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign instr_valid    = (count_q != '0);
   assign instr_data     = instr_valid ? data_q[rd_ptr_q]  : '0;
   assign instr_pc       = instr_valid ? pc_q[rd_ptr_q]    : '0;
   assign instr_fault    = instr_valid ? fault_q[rd_ptr_q] : 1'b0;
   assign count          = count_q;
   assign pop            = instr_valid && instr_ready;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      run_ok_d   = 1'b1;
      data_d     = data_q;
      pc_d       = pc_q;
      fault_d    = fault_q;
      push       = 1'b0;
      push_data  = '0;
      push_fault = 1'b0;
      misaligned = (redirect_pc[1:0] != 2'b00);
      // A response is still owed if one was accepted this cycle, or one is in
      // flight and is not arriving right now. A response coinciding with the
      // redirect is simply dropped; waiting for another would deadlock.
      owed       = req_fire ||
                   (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !imem_rsp_valid);

      if (redirect_valid) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = redirect_pc;
         if (misaligned) begin
            data_d[0]  = '0;
            pc_d[0]    = redirect_pc;
            fault_d[0] = 1'b1;
            wr_ptr_d   = PTR_W'(1);
            count_d    = CNT_W'(1);
         end
         if (owed)            state_d = ST_DRAIN;
         else if (misaligned) state_d = ST_HALT;
         else                 state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (req_fire) begin
                  state_d    = ST_WAIT;
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + ADDR_W'(4);
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  push       = 1'b1;
                  push_data  = imem_rsp_err ? '0 : imem_rsp_data;
                  push_fault = imem_rsp_err;
                  state_d    = imem_rsp_err ? ST_HALT : ST_RUN;
               end
            end
            ST_DRAIN: begin
               // fetch_pc already holds the pending target; a misaligned one
               // means its fault entry is queued and fetching must stay off.
               if (imem_rsp_valid) begin
                  state_d = (fetch_pc_q[1:0] != 2'b00) ? ST_HALT : ST_RUN;
               end
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase

         if (push) begin
            data_d[wr_ptr_q]  = push_data;
            pc_d[wr_ptr_q]    = req_pc_q;
            fault_d[wr_ptr_q] = push_fault;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         run_ok_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         run_ok_q   <= run_ok_d;
      end
   end

   // Queue storage needs no reset: the head outputs are masked while empty.
   always_ff @(posedge clk) begin
      data_q  <= data_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue: directed scenarios plus a
//             randomized phase, compared every cycle against a queue-based
//             reference model of the fetch unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

   localparam int ADDR_W = 32;
   localparam int XLEN   = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic              clk;
   logic              reset_n;
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [XLEN-1:0]   imem_rsp_data;
   logic              imem_rsp_err;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [XLEN-1:0]   instr_data;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_fault;
   logic [CNT_W-1:0]  count;

   fetch_queue #(
      .ADDR_W(ADDR_W), .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .imem_rsp_err(imem_rsp_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc), .instr_fault(instr_fault),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // stimulus knobs
   int          rdy_pct, ir_pct, err_pct, lat_min, lat_max;
   bit          err_addr_en;
   logic [31:0] err_addr;
   bit          redir_req;
   logic [31:0] redir_target;

   // memory responder state
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;

   // reference model
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        fault;
   } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc, m_out_pc;
   bit          m_out, m_drop, m_halt, m_started;

   // observation logs
   int          fire_cnt;
   logic [31:0] fire_addr[$];
   logic [31:0] pop_pc[$];
   logic        pop_fault[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc      = 32'h0;
      m_out_pc  = 32'h0;
      m_out     = 0;
      m_drop    = 0;
      m_halt    = 0;
      m_started = 0;
   endtask

   // One clock cycle: drive inputs at the falling edge, check outputs against
   // the model, then advance the model to the state after the next rising edge.
   task automatic cycle();
      bit   exp_rv, fire, pop, owed, rsp_v;
      logic [31:0] tgt;
      @(negedge clk);
      rsp_v = 0;
      if (mem_busy) begin
         if (mem_cnt == 0) rsp_v = 1;
         else mem_cnt--;
      end
      imem_rsp_valid = rsp_v;
      imem_rsp_data  = rsp_v ? mem_word(mem_addr) : $urandom;
      imem_rsp_err   = rsp_v && ((err_addr_en && mem_addr == err_addr) ||
                                 ($urandom_range(99) < err_pct));
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      instr_ready    = ($urandom_range(99) < ir_pct);
      redirect_valid = redir_req;
      redirect_pc    = redir_req ? redir_target : $urandom;
      redir_req      = 0;
      #1;
      exp_rv = m_started && !m_out && !m_halt && (mq.size() < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("count", count, mq.size());
      chk("instr_valid", instr_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("instr_pc", instr_pc, mq[0].pc);
         chk("instr_data", instr_data, mq[0].data);
         chk("instr_fault", instr_fault, mq[0].fault);
      end else begin
         chk("instr_pc_idle", instr_pc, 0);
         chk("instr_data_idle", instr_data, 0);
         chk("instr_fault_idle", instr_fault, 0);
      end

      // memory and logs follow what the DUT actually does
      if (rsp_v) mem_busy = 0;
      if (imem_req_valid && imem_req_ready) begin
         fire_cnt++;
         fire_addr.push_back(imem_req_addr);
         mem_busy = 1;
         mem_addr = imem_req_addr;
         mem_cnt  = $urandom_range(lat_max - 1, lat_min - 1);
      end
      if (instr_valid && instr_ready) begin
         pop_pc.push_back(instr_pc);
         pop_fault.push_back(instr_fault);
      end

      // reference model step
      fire = exp_rv && imem_req_ready;
      pop  = (mq.size() != 0) && instr_ready;
      if (redirect_valid) begin
         owed = fire || (m_out && !imem_rsp_valid);
         tgt  = redirect_pc;
         mq.delete();
         m_pc   = tgt;
         m_halt = (tgt[1:0] != 2'b00);
         if (m_halt) mq.push_back('{tgt, 32'h0, 1'b1});
         m_out  = owed;
         m_drop = owed;
      end else begin
         if (pop) void'(mq.pop_front());
         if (fire) begin
            m_out    = 1;
            m_drop   = 0;
            m_out_pc = m_pc;
            m_pc     = m_pc + 32'd4;
         end else if (m_out && imem_rsp_valid) begin
            m_out = 0;
            if (!m_drop) begin
               if (imem_rsp_err) begin
                  mq.push_back('{m_out_pc, 32'h0, 1'b1});
                  m_halt = 1;
               end else begin
                  mq.push_back('{m_out_pc, imem_rsp_data, 1'b0});
               end
            end
            m_drop = 0;
         end
      end
      m_started = 1;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
   task automatic do_reset();
      @(posedge clk);
      #2;
      reset_n        = 0;
      imem_rsp_valid = 0;
      redirect_valid = 0;
      imem_req_ready = 0;
      instr_ready    = 0;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr_data", instr_data, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_instr_fault", instr_fault, 0);
      chk("rst_count", count, 0);
      @(posedge clk);
      #2;
      reset_n = 1;
      model_reset();
   endtask

   initial begin
      int n;
      reset_n = 0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
      redirect_valid = 0; redirect_pc = '0; instr_ready = 0;
      rdy_pct = 100; ir_pct = 100; err_pct = 0; lat_min = 1; lat_max = 1;
      err_addr_en = 0; err_addr = '0; redir_req = 0; redir_target = '0;
      mem_busy = 0; mem_cnt = 0; mem_addr = '0; fire_cnt = 0;
      model_reset();

      // 1: zero-wait memory, decode always ready
      do_reset();
      pop_pc.delete();
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("t1_count_le1", count <= 1, 1);
      end
      chk("t1_pop_cnt", pop_pc.size() >= 4, 1);
      if (pop_pc.size() >= 4) begin
         chk("t1_pc0", pop_pc[0], 32'h0);
         chk("t1_pc1", pop_pc[1], 32'h4);
         chk("t1_pc2", pop_pc[2], 32'h8);
         chk("t1_pc3", pop_pc[3], 32'hC);
      end

      // 2: decode stalled, queue fills
      do_reset();
      ir_pct = 0; fire_cnt = 0;
      repeat (30) cycle();
      chk("t2_fires", fire_cnt, 4);
      chk("t2_count_full", count, 4);
      chk("t2_req_off", imem_req_valid, 0);
      fire_addr.delete();
      ir_pct = 100; cycle(); ir_pct = 0;
      n = 0;
      while (fire_addr.size() == 0 && n < 20) begin cycle(); n++; end
      chk("t2_refetch", fire_addr.size() > 0 ? fire_addr[0] : 32'hxxxx_xxxx, 32'h10);

      // 3: redirect while a request is outstanding
      do_reset();
      ir_pct = 100; lat_min = 3; lat_max = 3;
      n = 0;
      while (!mem_busy && n < 20) begin cycle(); n++; end
      chk("t3_outstanding", mem_busy, 1);
      redir_req = 1; redir_target = 32'h100;
      fire_addr.delete(); pop_pc.delete();
      cycle();
      cycle();
      chk("t3_flushed", count, 0);
      n = 0;
      while (pop_pc.size() == 0 && n < 40) begin cycle(); n++; end
      chk("t3_first_req", fire_addr.size() > 0 ? fire_addr[0] : 32'hxxxx_xxxx, 32'h100);
      chk("t3_first_pc", pop_pc.size() > 0 ? pop_pc[0] : 32'hxxxx_xxxx, 32'h100);

      // 4: misaligned redirect yields a single fault entry and halts fetching
      lat_min = 1; lat_max = 1;
      redir_req = 1; redir_target = 32'h102;
      cycle();
      ir_pct = 0;
      cycle();
      chk("t4_pc", instr_pc, 32'h102);
      chk("t4_fault", instr_fault, 1);
      chk("t4_count", count, 1);
      fire_cnt = 0;
      repeat (10) cycle();
      chk("t4_no_fetch", fire_cnt, 0);
      redir_req = 1; redir_target = 32'h200; ir_pct = 100;
      fire_addr.delete();
      n = 0;
      while (fire_addr.size() == 0 && n < 20) begin cycle(); n++; end
      chk("t4_resume", fire_addr.size() > 0 ? fire_addr[0] : 32'hxxxx_xxxx, 32'h200);

      // 5: bus error on the fetch at 0x8
      do_reset();
      err_addr_en = 1; err_addr = 32'h8; fire_cnt = 0;
      pop_pc.delete(); pop_fault.delete();
      repeat (30) cycle();
      chk("t5_pops", pop_pc.size(), 3);
      if (pop_pc.size() == 3) begin
         chk("t5_pc0", pop_pc[0], 32'h0);
         chk("t5_pc2", pop_pc[2], 32'h8);
         chk("t5_f1", pop_fault[1], 0);
         chk("t5_f2", pop_fault[2], 1);
      end
      chk("t5_fires", fire_cnt, 3);
      chk("t5_halted", imem_req_valid, 0);
      err_addr_en = 0;

      // 6: PC wrap, then reset while a request is outstanding
      redir_req = 1; redir_target = 32'hFFFF_FFFC;
      fire_addr.delete();
      n = 0;
      while (fire_addr.size() < 2 && n < 20) begin cycle(); n++; end
      chk("t6_addr_top", fire_addr.size() > 0 ? fire_addr[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
      chk("t6_addr_wrap", fire_addr.size() > 1 ? fire_addr[1] : 32'hxxxx_xxxx, 32'h0);
      lat_min = 3; lat_max = 3;
      n = 0;
      while (!(mem_busy && mem_cnt > 0) && n < 20) begin cycle(); n++; end
      do_reset();
      rdy_pct = 0;
      repeat (6) cycle();
      chk("t6_late_rsp_ignored", count, 0);
      rdy_pct = 100;

      // randomized phase
      lat_min = 1; lat_max = 3; err_pct = 4;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(15) == 0) begin
            rdy_pct = $urandom_range(30, 100);
            ir_pct  = $urandom_range(0, 100);
         end
         if ($urandom_range(24) == 0) begin
            redir_req    = 1;
            redir_target = ($urandom & 32'h0000_0FFC) |
                           (($urandom_range(7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            if ($urandom_range(19) == 0) redir_target = 32'hFFFF_FFF8;
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
